// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared definitions for the multi-port register file.
//   MODE_ADDR / MODE_LOG : encoding of the per-cycle 'mode' input
//   DEF_DATA_W / DEF_DEPTH : default word width and register count shared
//                            with the ALU datapath
package reg_file_mp_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_LOG  = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus bundle between the ALU datapath and reg_file_mp.
//   master : datapath side (drives mode/clear/we/waddr/wdata/raddr_a/raddr_b)
//   slave  : register file side (drives rdata_a/rdata_b/wptr/count/full/dup)
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
);
    logic              mode;
    logic              clear;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [DATA_W-1:0] rdata_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_b;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              dup;

    modport master (
        output mode, clear, we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, wptr, count, full, dup
    );

    modport slave (
        input  mode, clear, we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, wptr, count, full, dup
    );
endinterface

// File: rtl/reg_file_log_ctrl.sv
// reg_file_log_ctrl: write-side control for reg_file_mp.
// Holds the log-mode circular-buffer state (wptr, count, last_val,
// last_valid) and the duplicate compare, and resolves each cycle's write
// into one accept strobe plus the effective write address.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   mode, clear, we     : per-cycle write controls
//   waddr, wdata        : write address (addressed mode) and data
//   wr_en, wr_addr      : accepted write strobe and effective address
//   wptr, count, full   : log buffer status
//   dup                 : one-cycle pulse after a suppressed duplicate
module reg_file_log_ctrl
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              dup
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] last_val;
    logic              last_valid;
    logic              log_we;
    logic              log_new;
    logic              log_acc;
    logic              addr_acc;

    // A cleared log has no previous value, so the next write is always new.
    assign log_we   = we && (mode == MODE_LOG) && !clear;
    assign log_new  = !last_valid || (wdata != last_val);
    assign log_acc  = log_we && log_new;
    // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
    assign addr_acc = we && (mode == MODE_ADDR) && ({1'b0, waddr} < DEPTH_C);

    assign wr_en   = log_acc || addr_acc;
    assign wr_addr = (mode == MODE_LOG) ? wptr : waddr;
    assign full    = (count == DEPTH_C);

    // ---- log state register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            count      <= '0;
            last_val   <= '0;
            last_valid <= 1'b0;
            dup        <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            count      <= '0;
            last_valid <= 1'b0;
            dup        <= 1'b0;
        end else begin
            dup <= log_we && !log_new;
            if (log_acc) begin
                last_val   <= wdata;
                last_valid <= 1'b1;
                wptr       <= (wptr == LAST_C) ? '0 : wptr + 1'b1;
                // Once full, the oldest entry is overwritten and count holds.
                if (count != DEPTH_C)
                    count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: one-write / two-read register file for the ALU datapath,
// with a run-time log mode that appends only changed values to a circular
// buffer.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous active-high reset (memory, read data, log state)
//   bus   : reg_file_mp_if.slave -- write/read ports and log status
// Configuration macro: REG_FILE_MP_BYPASS_EN
//   defined   -> a read of the address being written this cycle returns
//                wdata (write-through forwarding, both ports, both modes)
//   undefined -> the same collision returns the old memory contents
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            reset,
    reg_file_mp_if.slave   bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              dup;
    logic [DATA_W-1:0] rdata_a_p1;
    logic [DATA_W-1:0] rdata_b_p1;

    reg_file_log_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_log_ctrl (
        .clk     (clk),
        .reset   (reset),
        .mode    (bus.mode),
        .clear   (bus.clear),
        .we      (bus.we),
        .waddr   (bus.waddr),
        .wdata   (bus.wdata),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wptr    (wptr),
        .count   (count),
        .full    (full),
        .dup     (dup)
    );

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        if ({1'b0, a} >= DEPTH_C) begin
            w = '0;
        end else begin
            w = mem[a];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_en && (a == wr_addr))
                w = bus.wdata;
`endif
        end
        return w;
    endfunction

    // ---- memory write and read register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rdata_a_p1 <= '0;
            rdata_b_p1 <= '0;
        end else begin
            if (wr_en)
                mem[wr_addr] <= bus.wdata;
            rdata_a_p1 <= read_word(bus.raddr_a);
            rdata_b_p1 <= read_word(bus.raddr_b);
        end
    end

    assign bus.rdata_a = rdata_a_p1;
    assign bus.rdata_b = rdata_b_p1;
    assign bus.wptr    = wptr;
    assign bus.count   = count;
    assign bus.full    = full;
    assign bus.dup     = dup;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench for reg_file_mp (DATA_W=8, DEPTH=8).
// Expected outputs are queued when a step is driven and compared after the
// following rising edge. Honours REG_FILE_MP_BYPASS_EN for collision reads.
module tb_reg_file_mp;
    import reg_file_mp_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    localparam int S_RA = 0, S_RB = 1, S_WPTR = 2, S_CNT = 3, S_FULL = 4, S_DUP = 5;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    reg_file_mp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    reg_file_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            S_RA:    return 32'(bus.rdata_a);
            S_RB:    return 32'(bus.rdata_b);
            S_WPTR:  return 32'(bus.wptr);
            S_CNT:   return 32'(bus.count);
            S_FULL:  return 32'(bus.full);
            default: return 32'(bus.dup);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic expect_log(input string tag, input int wp, input int cnt,
                              input int fl, input int dp);
        expect_val({tag, "_wptr"},  S_WPTR, 32'(wp));
        expect_val({tag, "_count"}, S_CNT,  32'(cnt));
        expect_val({tag, "_full"},  S_FULL, 32'(fl));
        expect_val({tag, "_dup"},   S_DUP,  32'(dp));
    endtask

    // Advance one edge, then compare everything queued for that edge.
    task automatic cyc();
        exp_t e;
        logic [31:0] o;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sig);
            n_cmp++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic idle();
        bus.we    = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic log_wr(input logic [7:0] d);
        bus.mode  = MODE_LOG;
        bus.we    = 1'b1;
        bus.wdata = d;
    endtask

    logic [7:0] byp;

    initial begin
        reset       = 1'b1;
        bus.mode    = MODE_ADDR;
        bus.clear   = 1'b0;
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;

        // Reset state
        cyc();
        expect_val("rst_ra", S_RA, 0);
        expect_val("rst_rb", S_RB, 0);
        expect_log("rst", 0, 0, 0, 0);
        cyc();
        reset = 1'b0;

        // Addressed writes then two-port read
        bus.we = 1'b1; bus.waddr = 3; bus.wdata = 8'h11;
        cyc();
        bus.waddr = 5; bus.wdata = 8'h22;
        cyc();
        bus.we = 1'b0; bus.raddr_a = 3; bus.raddr_b = 5;
        expect_val("rd_a3", S_RA, 8'h11);
        expect_val("rd_b5", S_RB, 8'h22);
        expect_log("addr", 0, 0, 0, 0);
        cyc();

        // Same-cycle write/read collision, addressed mode
`ifdef REG_FILE_MP_BYPASS_EN
        byp = 8'h5C;
`else
        byp = 8'h00;
`endif
        bus.we = 1'b1; bus.waddr = 2; bus.wdata = 8'h5C; bus.raddr_a = 2;
        expect_val("coll_a2", S_RA, 32'(byp));
        cyc();
        bus.we = 1'b0;
        expect_val("after_coll_a2", S_RA, 8'h5C);
        cyc();

        // Log mode duplicate suppression
        log_wr(8'hA0); expect_log("log1", 1, 1, 0, 0); cyc();
        log_wr(8'hA0); expect_log("log2dup", 1, 1, 0, 1); cyc();
        log_wr(8'hA1); expect_log("log3", 2, 2, 0, 0); cyc();
        idle(); bus.raddr_a = 0; bus.raddr_b = 1;
        expect_val("log_m0", S_RA, 8'hA0);
        expect_val("log_m1", S_RB, 8'hA1);
        expect_log("log_idle", 2, 2, 0, 0);
        cyc();

        // clear beats a same-cycle log write
        log_wr(8'h77); bus.clear = 1'b1;
        expect_log("clr_wr", 0, 0, 0, 0);
        cyc();
        bus.clear = 1'b0;
        log_wr(8'h77); expect_log("post_clr", 1, 1, 0, 0); cyc();
        // clear alone must forget last_val so the same value is accepted
        idle(); bus.clear = 1'b1; expect_log("clr2", 0, 0, 0, 0); cyc();
        bus.clear = 1'b0;
        log_wr(8'h77); expect_log("same_after_clr", 1, 1, 0, 0); cyc();

        // Fill and wrap the log buffer
        idle(); bus.clear = 1'b1; cyc();
        bus.clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            log_wr(8'h30 + 8'(i));
            expect_log($sformatf("fill%0d", i), (i + 1) % 8, (i < 8) ? i + 1 : 8,
                       (i >= 7) ? 1 : 0, 0);
            cyc();
        end
        idle(); bus.raddr_a = 0; bus.raddr_b = 7;
        expect_val("wrap_m0", S_RA, 8'h38);
        expect_val("wrap_m7", S_RB, 8'h37);
        cyc();

        // Addressed write leaves log state alone
        bus.mode = MODE_ADDR; bus.we = 1'b1; bus.waddr = 6; bus.wdata = 8'hE6;
        expect_log("addr_keep", 1, 8, 1, 0);
        cyc();
        idle(); bus.raddr_a = 6;
        expect_val("addr_m6", S_RA, 8'hE6);
        cyc();

        // Reset mid log sequence
        bus.clear = 1'b1; cyc();
        bus.clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            log_wr(8'h40 + 8'(i));
            cyc();
        end
        reset = 1'b1; log_wr(8'h55); bus.raddr_a = 0; bus.raddr_b = 4;
        expect_val("mid_rst_ra", S_RA, 0);
        expect_val("mid_rst_rb", S_RB, 0);
        expect_log("mid_rst", 0, 0, 0, 0);
        cyc();
        reset = 1'b0; idle(); bus.mode = MODE_ADDR;
        expect_val("rst_m0", S_RA, 0);
        expect_val("rst_m4", S_RB, 0);
        cyc();
        bus.raddr_a = 3; bus.raddr_b = 2;
        expect_val("rst_m3", S_RA, 0);
        expect_val("rst_m2", S_RB, 0);
        cyc();

        // Log-mode collision: effective address is wptr
`ifdef REG_FILE_MP_BYPASS_EN
        byp = 8'h99;
`else
        byp = 8'h00;
`endif
        log_wr(8'h99); bus.raddr_a = 0;
        expect_val("log_coll", S_RA, 32'(byp));
        expect_log("log_coll", 1, 1, 0, 0);
        cyc();
        idle();
        expect_val("log_coll_after", S_RA, 8'h99);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the 8-bit RISC datapath, replacing the single-port auto-advancing register bank. Provides one write port and two registered read ports for ALU operand fetch. A run-time selectable log mode keeps the legacy behaviour: ALU results go into a circular buffer only when the value changes. Sits between the ALU result bus and the ALU operand inputs.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- DEPTH, 8, number of registers (≥2; power of two not required)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- mode  in  1  0 = addressed write, 1 = log write
- clear  in  1  synchronous clear of log state only; memory is not cleared
- we  in  1  write enable
- waddr  in  ADDR_W  write address, used in addressed mode only
- wdata  in  DATA_W  write data (ALU result)
- raddr_a  in  ADDR_W  read port A address
- rdata_a  out  DATA_W  read port A data, registered
- raddr_b  in  ADDR_W  read port B address
- rdata_b  out  DATA_W  read port B data, registered
- wptr  out  ADDR_W  log-mode next write slot
- count  out  ADDR_W+1  valid log entries, saturating at DEPTH
- full  out  1  count == DEPTH
- dup  out  1  one-cycle pulse: log write suppressed as duplicate

## Operation
- Reset: all DEPTH words = 0, rdata_a/b = 0, wptr = 0, count = 0, full = 0, dup = 0, last_valid = 0, last_val = 0.
- Addressed mode (mode=0), we=1: mem[waddr] <= wdata. wptr, count and last_val are unchanged. If waddr ≥ DEPTH, the write is dropped.
- Log mode (mode=1), we=1: waddr is ignored.
  - The write is accepted if last_valid==0 or wdata != last_val.
  - On accept: mem[wptr] <= wdata; last_val <= wdata; last_valid <= 1; wptr <= (wptr==DEPTH-1) ? 0 : wptr+1; count <= min(count+1, DEPTH).
  - When full, the oldest entry is overwritten and count stays DEPTH.
  - On reject: no state change; dup=1 for that cycle.
- clear=1: wptr, count and last_valid go to 0 and dup goes to 0. Memory and rdata are untouched. clear takes priority over a same-cycle log write, which is dropped. A same-cycle addressed write still proceeds.
- Priority: reset > clear > write.
- mode may change on any cycle and is sampled per cycle. Log state persists across addressed-mode periods.
- Reads: each port returns mem[raddr] registered every cycle; there is no read enable. raddr ≥ DEPTH returns 0.

## Timing
- Read latency is 1 cycle: raddr sampled at edge N gives rdata valid after edge N, held until the next edge.
- A write at edge N is visible to a read address sampled at edge N+1.
- Same-cycle read/write of the same address: behaviour is set by the macro in Configuration.
- dup is asserted in the same cycle as the rejected we, from combinational compare registered at edge. It is visible for the one cycle following that edge.
- wptr, count and full update at the accepting edge.

## Configuration
- REG_FILE_MP_BYPASS_EN defined: a read address matching the effective write address on a cycle with an accepted write returns wdata (write-through forwarding). This applies to both ports and both modes; in log mode the effective address is wptr.
- Macro undefined: the same collision returns the old memory contents.

## Structure
- Package reg_file_mp_pkg holds:
  - the mode encoding constants MODE_ADDR=1'b0 and MODE_LOG=1'b1
  - the default DATA_W and DEPTH values shared with the ALU.
- Sub-module reg_file_log_ctrl holds wptr, count, full, last_val, last_valid and the dup compare. Its outputs are the accept strobe and the effective write address.
- The top level holds the memory array, address decode and read registers.

## Test plan
- Reset, then addressed-write 8'h11 to reg 3 and 8'h22 to reg 5; read A=3, B=5 -> rdata_a=8'h11, rdata_b=8'h22 one cycle later.
- Log mode: write 8'hA0, 8'hA0, 8'hA1 -> second write gives dup=1; mem[0]=A0, mem[1]=A1, wptr=2, count=2.
- Log mode: 9 distinct writes at DEPTH=8 -> full=1 after the 8th; the 9th overwrites mem[0]; wptr=1; count stays 8.
- Same-cycle write 8'h5C to reg 2 with raddr_a=2 -> rdata_a=8'h5C with the macro defined, old value (0) without it.
- clear asserted together with a log write of 8'h77 -> write dropped, wptr=0, count=0. The next write of the same value 8'h77 is accepted (last_valid cleared).
- reset asserted mid-sequence after 5 log writes -> all outputs return to their reset values on the next edge; memory reads return 0.
